// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state, queue entry type and default sizes for the fetch front end.
package fetch_pkg;
  localparam int FETCH_ADDR_W = 16;
  localparam int FETCH_INSTR_W = 16;
  localparam int FETCH_DEPTH = 4;
  localparam int FETCH_PC_STEP = 2;
  localparam int FETCH_RESET_PC = 0;
  typedef enum logic [1:0] {IDLE, ISSUE, DISCARD} fetch_state_t;
  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched {instr, pc} words with flush and a held head.
module fetch_queue import fetch_pkg::*; #(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int W = FETCH_INSTR_W + FETCH_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] held;
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full & ~flush;
  assign do_pop = pop & ~empty & ~flush;
  // once drained, the head keeps presenting the last word it showed
  assign head = empty ? held : mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      held <= '0;
    end else begin
      held <= head;
      rd <= flush ? '0 : rd + AW'(do_pop);
      wr <= flush ? '0 : wr + AW'(do_push);
      count <= flush ? '0 : count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: fetch FSM with one outstanding req/ack read, prefetch queue and redirect flush.
// FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_stall / perf_flush counters.
module fetch_prefetch_unit import fetch_pkg::*; #(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter int DEPTH = FETCH_DEPTH,
  parameter int PC_STEP = FETCH_PC_STEP,
  parameter int RESET_PC = FETCH_RESET_PC
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall,
  output logic [15:0]        perf_flush
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t state, state_nx;
  logic [ADDR_W-1:0] fetch_pc, pc_nx, addr_nx;
  logic [CW-1:0] count, count_nx;
  logic [INSTR_W+ADDR_W-1:0] head;
  logic hold, push, pop, full, empty, space;
  assign hold = mem_req & ~mem_ack;
  assign push = mem_req & mem_ack & (state == ISSUE) & ~redirect_valid & ~full;
  assign pop = instr_valid & instr_ready & ~redirect_valid;
  // occupancy after this edge; the current request has retired whenever a new one may start
  assign count_nx = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
  assign space = count_nx < CW'(DEPTH);
  assign instr_valid = ~empty;
  assign {instr, instr_pc} = head;
  always_comb begin
    pc_nx = redirect_valid ? redirect_pc : push ? fetch_pc + ADDR_W'(PC_STEP) : fetch_pc;
    state_nx = hold ? (redirect_valid ? DISCARD : state) : (space ? ISSUE : IDLE);
    addr_nx = hold ? mem_addr : pc_nx;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      fetch_pc <= ADDR_W'(RESET_PC);
      mem_req <= 1'b0;
      mem_addr <= ADDR_W'(RESET_PC);
    end else begin
      state <= state_nx;
      fetch_pc <= pc_nx;
      mem_req <= state_nx != IDLE;
      mem_addr <= addr_nx;
    end
  fetch_queue #(.DEPTH(DEPTH), .W(INSTR_W + ADDR_W)) u_queue (
    .clk(CLK),
    .rst(RST),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .wdata({mem_rdata, fetch_pc}),
    .head(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      perf_fetched <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (push && !(&perf_fetched)) perf_fetched <= perf_fetched + 32'd1;
      if (hold && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
      if (redirect_valid && !(&perf_flush)) perf_flush <= perf_flush + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: scoreboard bench with a wait-state memory model and directed scenarios.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;
  logic CLK, RST, mem_req, mem_ack, instr_valid, instr_ready, redirect_valid;
  logic [15:0] mem_addr, mem_rdata, instr, instr_pc, redirect_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
  logic [15:0] perf_flush;
`endif
  int checks = 0, errors = 0, wait_n = 0, wcnt = 0, n_push = 0, w;
  logic stray = 0, busy = 0, tainted = 0, saw8 = 0, found;
  logic [15:0] exp_pc = 0, cur_addr = 0;
  fetch_entry_t sb[$];

  fetch_prefetch_unit dut (
    .CLK(CLK),
    .RST(RST),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall),
    .perf_flush(perf_flush)
`endif
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory: ack after wait_n wait cycles, data derived from the address
  initial begin
    mem_ack = 0;
    mem_rdata = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (mem_req) begin
        if (wcnt == wait_n) begin
          mem_ack = 1;
          mem_rdata = mem_addr ^ 16'hA5C3;
          wcnt = 0;
        end else begin
          mem_ack = 0;
          wcnt++;
        end
      end else begin
        mem_ack = stray;
        mem_rdata = 16'hDEAD;
        wcnt = 0;
      end
    end
  end

  // scoreboard: outputs checked against the model, then the model steps for the coming edge
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      sb.delete();
      exp_pc = 0;
      busy = 0;
      tainted = 0;
      n_push = 0;
    end else begin
      if (mem_req) begin
        if (!busy) begin
          check("req_addr", mem_addr, exp_pc);
          cur_addr = mem_addr;
        end else check("req_hold", mem_addr, cur_addr);
      end
      check("valid", instr_valid, sb.size() != 0);
      if (sb.size() != 0) begin
        check("head_instr", instr, sb[0].instr);
        check("head_pc", instr_pc, sb[0].pc);
      end
      if (instr_valid && instr_pc == 16'h0008) saw8 = 1;
      if (redirect_valid) begin
        sb.delete();
        exp_pc = redirect_pc;
        tainted = mem_req & ~mem_ack;
      end else begin
        if (instr_valid && instr_ready && sb.size() != 0) void'(sb.pop_front());
        if (mem_req && mem_ack) begin
          if (!tainted) begin
            sb.push_back('{instr: mem_rdata, pc: cur_addr});
            exp_pc = cur_addr + 16'd2;
            n_push++;
          end
          tainted = 0;
        end
      end
      busy = mem_req & ~mem_ack;
    end
  end

  task automatic do_reset();
    @(posedge CLK);
    #2 RST = 1;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
    @(posedge CLK);
    #1 RST = 0;
  endtask

  task automatic wait_req();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      found = mem_req;
    end
  endtask

  initial begin
    RST = 1;
    redirect_valid = 0;
    redirect_pc = 0;
    instr_ready = 1;
    // zero-wait streaming from RESET_PC
    do_reset();
    wait_req();
    check("t1_req", found, 1);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", mem_addr, 2 * i);
      if (i > 0) check("t1_pc", instr_pc, 2 * (i - 1));
      @(negedge CLK);
    end
    // fill to DEPTH with decode stalled, stray acks ignored, one pop refills once
    instr_ready = 0;
    do_reset();
    repeat (10) @(negedge CLK);
    check("t2_pushes", n_push, 4);
    check("t2_req_off", mem_req, 0);
    check("t2_head", instr_pc, 0);
    stray = 1;
    repeat (3) @(negedge CLK);
    stray = 0;
    check("t2_stray_req", mem_req, 0);
    check("t2_stray_push", n_push, 4);
    @(posedge CLK);
    #1 instr_ready = 1;
    @(posedge CLK);
    #1 instr_ready = 0;
    @(negedge CLK);
    check("t2_refill_req", mem_req, 1);
    check("t2_refill_addr", mem_addr, 16'h0008);
    repeat (4) @(negedge CLK);
    check("t2_full_req", mem_req, 0);
    check("t2_full_push", n_push, 5);
    check("t2_full_head", instr_pc, 2);
    // three wait states per fetch
    wait_n = 3;
    instr_ready = 1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      w = 0;
      for (int i = 0; i < 20 && !(mem_req && mem_ack); i++) begin
        if (mem_req) w++;
        @(negedge CLK);
      end
      check("t3_wait", w, 3);
`ifdef FETCH_PERF_CNT_EN
      check("t3_perf_stall", perf_stall, 3 * (k + 1));
      check("t3_perf_fetched", perf_fetched, k);
`endif
      @(negedge CLK);
    end
    // redirect while the request to 0x0008 is waiting
    do_reset();
    saw8 = 0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge CLK);
      found = mem_req && mem_addr == 16'h0008;
    end
    check("t4_reach8", found, 1);
    @(posedge CLK);
    #1 redirect_valid = 1;
    redirect_pc = 16'h0100;
    @(posedge CLK);
    #1 redirect_valid = 0;
    @(negedge CLK);
    check("t4_empty", instr_valid, 0);
    check("t4_discard_req", mem_req, 1);
    check("t4_discard_addr", mem_addr, 16'h0008);
`ifdef FETCH_PERF_CNT_EN
    check("t4_perf_flush", perf_flush, 1);
`endif
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CLK);
      found = mem_req && mem_addr == 16'h0100;
    end
    check("t4_new_addr", found, 1);
    repeat (8) @(negedge CLK);
    check("t4_no_stale", saw8, 0);
    // redirect in the same cycle as ack and pop
    wait_n = 0;
    do_reset();
    repeat (6) @(negedge CLK);
    @(posedge CLK);
    #1 redirect_valid = 1;
    redirect_pc = 16'h0200;
    @(negedge CLK);
    check("t5_ack", mem_req & mem_ack, 1);
    check("t5_valid", instr_valid, 1);
    @(posedge CLK);
    #1 redirect_valid = 0;
    @(negedge CLK);
    check("t5_req", mem_req, 1);
    check("t5_addr", mem_addr, 16'h0200);
    check("t5_empty", instr_valid, 0);
    @(negedge CLK);
    check("t5_first_pc", instr_pc, 16'h0200);
    // asynchronous reset in the middle of a wait
    wait_n = 3;
    instr_ready = 0;
    do_reset();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge CLK);
      found = n_push >= 2 && mem_req && !mem_ack;
    end
    check("t6_midwait", found, 1);
    check("t6_pre_valid", instr_valid, 1);
    @(posedge CLK);
    #2 RST = 1;
    #1;
    check("t6_req", mem_req, 0);
    check("t6_addr", mem_addr, 0);
    check("t6_valid", instr_valid, 0);
    check("t6_instr", instr, 0);
    check("t6_pc", instr_pc, 0);
    @(posedge CLK);
    #1 RST = 0;
    wait_req();
    check("t6_resume_req", found, 1);
    check("t6_resume_addr", mem_addr, 0);
    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised instruction-fetch front end for the multi-cycle CPU. It replaces the single-IR fetch step with a fetch FSM and a small prefetch queue. It issues one outstanding read at a time to instruction memory using a req/ack handshake, buffers returned words with their PCs, and hands them to decode through a valid/ready interface. It supports branch redirect with flush and discard of in-flight data.

Parameters:
ADDR_W, 16, PC and memory address width
INSTR_W, 16, instruction word width
DEPTH, 4, prefetch queue entries (power of two, >=2)
PC_STEP, 2, PC increment per fetched word
RESET_PC, 0, fetch PC loaded on reset

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
mem_req  out  1  read request, registered
mem_addr  out  ADDR_W  read address, stable while mem_req=1
mem_ack  in  1  read data valid this cycle
mem_rdata  in  INSTR_W  read data
instr_valid  out  1  queue head valid
instr  out  INSTR_W  queue head word
instr_pc  out  ADDR_W  PC of head word
instr_ready  in  1  decode consumes head when instr_valid=1
redirect_valid  in  1  branch/jump redirect pulse
redirect_pc  in  ADDR_W  redirect target

Behaviour:
- Reset (asynchronous): mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, queue empty, instr_valid=0, instr=0, instr_pc=0, state=IDLE.
- FSM states:
  - IDLE: enter ISSUE when the queue has space.
  - ISSUE: mem_req=1 and mem_addr=fetch_pc. Stay until mem_ack.
  - DISCARD: mem_req stays 1 until mem_ack; the returned data is dropped.
- Space rule: issue only if (count + in-flight) < DEPTH. A pop in the same cycle frees a slot.
- Handshake:
  - mem_req is held with a constant mem_addr until mem_ack is sampled high.
  - mem_ack while mem_req=0 is ignored.
- On ack in ISSUE at edge N:
  - push {mem_rdata, fetch_pc}
  - fetch_pc += PC_STEP (modulo 2^ADDR_W)
  - instr_valid=1 from cycle N+1.
- Back-to-back issue: mem_req may stay high into cycle N+1 with the new address if space remains. This gives one fetch per cycle with zero-wait memory.
- Pop: instr_valid & instr_ready at an edge advances the head. Push and pop in the same cycle leave count unchanged.
- Full (count=DEPTH): mem_req is deasserted after the current ack; no new issue until a pop.
- Empty: instr_valid=0; instr and instr_pc hold their last values.
- Redirect at edge R (highest priority):
  - queue flushed
  - fetch_pc=redirect_pc
  - any pop that cycle is ignored
  - instr_valid=0 in cycle R+1.
- Redirect timing cases:
  - No request outstanding: next request to redirect_pc in cycle R+1.
  - Request outstanding and mem_ack=0: enter DISCARD. After its ack, issue redirect_pc in the following cycle.
  - mem_ack=1 in the same cycle: the data is dropped, and redirect_pc is issued in cycle R+1.
  - Redirect while in DISCARD: update fetch_pc only, stay in DISCARD.
- RST asserted mid-transaction: everything resets immediately. The memory side must tolerate an abandoned request.
- Pointers are log2(DEPTH) bits with a separate count, so wrap-around is natural.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, three extra outputs are added, all reset to 0 and saturating at all-ones:
  - perf_fetched (32 bits): counts pushes
  - perf_stall (32 bits): counts cycles with mem_req=1 and mem_ack=0
  - perf_flush (16 bits): counts redirects
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - FSM state enum (IDLE, ISSUE, DISCARD)
  - queue entry struct {instr, pc}
  - default constants for widths and RESET_PC.
- One natural sub-module is fetch_queue: a parametrised synchronous FIFO with push, pop, flush, count, full and empty. The parent holds the FSM and the PC.

Test Plan:
1. Reset release with RESET_PC=0 and zero-wait ack, instr_ready=1: mem_addr sequence 0,2,4,6 on consecutive cycles; instr_pc follows one cycle behind the acks.
2. instr_ready=0 with DEPTH=4: exactly 4 pushes (PC 0..6), then mem_req=0. Raising instr_ready for one cycle leads to one new request at 8.
3. Memory with 3 wait states: mem_addr stays constant while mem_req=1 until ack; perf_stall increments by 3 per fetch (with FETCH_PERF_CNT_EN).
4. redirect_valid with redirect_pc=0x0100 while a request to 0x0008 is outstanding (ack 2 cycles later): the 0x0008 data never appears on instr; the next mem_addr is 0x0100; the queue is empty in cycle R+1.
5. Redirect coinciding with mem_ack and instr_ready: no push, no pop; next mem_addr is redirect_pc in cycle R+1.
6. RST asserted mid-wait: outputs return to reset values asynchronously, before the next clock edge; fetching resumes from RESET_PC after release.
